cpu_ctrl: RTL and testbench

CPU_CTRL -- requirements
Module: cpu_ctrl

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/cpu_ctrl_decode.sv | 36 +++
 rtl/cpu_ctrl.sv | 174 +++++++++++++++++
 tb/tb_cpu_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and field layout for the cpu_ctrl sequencer.
// Holds the opcode and state encodings used by the decoder and the FSM.
package cpu_pkg;

  typedef enum logic [1:0] {
    OP_MOV = 2'b00,
    OP_LDI = 2'b01,
    OP_ADD = 2'b10,
    OP_SYS = 2'b11
  } opcode_t;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_MOV,
    CLS_LDI,
    CLS_ADD,
    CLS_HALT
  } iclass_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_IMM,
    S_RD_RS,
    S_RD_RD,
    S_WRITE,
    S_HALT
  } state_t;

  localparam int OPC_LSB = 6;
  localparam int OPC_W   = 2;
  localparam int RD_LSB  = 3;
  localparam int RS_LSB  = 0;
  localparam int FIELD_W = 3;

  // The system opcode with this rs field halts; any other rs is a NOP.
  localparam logic [FIELD_W-1:0] HALT_RS = 3'b111;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational instruction decoder: splits ir into its class and the
// rd/rs register selects used by the cpu_ctrl FSM.
module cpu_ctrl_decode
  import cpu_pkg::*;
#(
  parameter int DW  = 8,
  parameter int RAW = 3
) (
  input  logic [DW-1:0]  ir,
  output iclass_t        iclass,
  output logic [RAW-1:0] rd,
  output logic [RAW-1:0] rs
);

  opcode_t              opc;
  logic [FIELD_W-1:0]   rd_f;
  logic [FIELD_W-1:0]   rs_f;

  always_comb begin
    opc  = opcode_t'(ir[OPC_LSB +: OPC_W]);
    rd_f = ir[RD_LSB +: FIELD_W];
    rs_f = ir[RS_LSB +: FIELD_W];
    iclass = CLS_NOP;
    case (opc)
      OP_MOV:  iclass = CLS_MOV;
      OP_LDI:  iclass = CLS_LDI;
      OP_ADD:  iclass = CLS_ADD;
      OP_SYS:  iclass = (rs_f == HALT_RS) ? CLS_HALT : CLS_NOP;
      default: iclass = CLS_NOP;
    endcase
  end

  assign rd = RAW'(rd_f);
  assign rs = RAW'(rs_f);

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle register-transfer controller driving a shared bus and register file.
// Optional ADD flags are built only when CPU_CTRL_FLAGS_EN is defined.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int DW  = 8,
  parameter int RAW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DW-1:0]  instr,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [DW-1:0]  bus_in,
  output logic [DW-1:0]  bus_out,
  output logic           bus_oe,
  output logic [RAW-1:0] reg_sel,
  output logic           reg_rd,
  output logic           reg_wr,
  output logic           halted,
  output logic           flag_z,
  output logic           flag_c
);

  state_t         state;
  state_t         nxt_state;
  logic [DW-1:0]  ir;
  logic [DW-1:0]  tmp;
  logic [DW-1:0]  nxt_tmp;
  logic [DW-1:0]  add_res;
  iclass_t        iclass;
  logic [RAW-1:0] rd;
  logic [RAW-1:0] rs;
  logic           ready_q;
  logic           xfer;

  logic           nxt_ready;
  logic           nxt_halted;
  logic           nxt_rd;
  logic           nxt_wr;
  logic           nxt_oe;
  logic [RAW-1:0] nxt_sel;
  logic [DW-1:0]  nxt_bus_out;

  cpu_ctrl_decode #(
    .DW  (DW),
    .RAW (RAW)
  ) u_decode (
    .ir     (ir),
    .iclass (iclass),
    .rd     (rd),
    .rs     (rs)
  );

  // Gating with rst keeps the handshake closed while reset is held.
  assign instr_ready = ready_q & rst;
  assign xfer        = instr_valid & instr_ready;

`ifdef CPU_CTRL_FLAGS_EN
  logic [DW:0] sum;
  logic        z_q;
  logic        c_q;

  assign sum     = {1'b0, bus_in} + {1'b0, tmp};
  assign add_res = sum[DW-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      z_q <= 1'b0;
      c_q <= 1'b0;
    end else if (state == S_RD_RD) begin
      z_q <= (sum[DW-1:0] == '0);
      c_q <= sum[DW];
    end
  end

  assign flag_z = z_q;
  assign flag_c = c_q;
`else
  assign add_res = bus_in + tmp;
  assign flag_z  = 1'b0;
  assign flag_c  = 1'b0;
`endif

  always_comb begin
    nxt_state = state;
    nxt_tmp   = tmp;
    case (state)
      S_FETCH:  if (xfer) nxt_state = S_DECODE;
      S_DECODE: begin
        case (iclass)
          CLS_MOV, CLS_ADD: nxt_state = S_RD_RS;
          CLS_LDI:          nxt_state = S_IMM;
          CLS_HALT:         nxt_state = S_HALT;
          default:          nxt_state = S_FETCH;
        endcase
      end
      S_IMM: begin
        if (xfer) begin
          nxt_tmp   = instr;
          nxt_state = S_WRITE;
        end
      end
      S_RD_RS: begin
        nxt_tmp   = bus_in;
        nxt_state = (iclass == CLS_ADD) ? S_RD_RD : S_WRITE;
      end
      S_RD_RD: begin
        nxt_tmp   = add_res;
        nxt_state = S_WRITE;
      end
      S_WRITE:  nxt_state = S_FETCH;
      S_HALT:   nxt_state = S_HALT;
      default:  nxt_state = S_FETCH;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    nxt_ready   = 1'b0;
    nxt_halted  = 1'b0;
    nxt_rd      = 1'b0;
    nxt_wr      = 1'b0;
    nxt_oe      = 1'b0;
    nxt_sel     = '0;
    nxt_bus_out = '0;
    case (nxt_state)
      S_FETCH, S_IMM: nxt_ready = 1'b1;
      S_RD_RS: begin
        nxt_sel = rs;
        nxt_rd  = 1'b1;
      end
      S_RD_RD: begin
        nxt_sel = rd;
        nxt_rd  = 1'b1;
      end
      S_WRITE: begin
        nxt_sel     = rd;
        nxt_oe      = 1'b1;
        nxt_wr      = 1'b1;
        nxt_bus_out = nxt_tmp;
      end
      S_HALT:  nxt_halted = 1'b1;
      default: nxt_ready  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_FETCH;
      ir      <= '0;
      tmp     <= '0;
      ready_q <= 1'b1;
      halted  <= 1'b0;
      reg_rd  <= 1'b0;
      reg_wr  <= 1'b0;
      bus_oe  <= 1'b0;
      reg_sel <= '0;
      bus_out <= '0;
    end else begin
      state   <= nxt_state;
      tmp     <= nxt_tmp;
      if (state == S_FETCH && xfer) ir <= instr;
      ready_q <= nxt_ready;
      halted  <= nxt_halted;
      reg_rd  <= nxt_rd;
      reg_wr  <= nxt_wr;
      bus_oe  <= nxt_oe;
      reg_sel <= nxt_sel;
      bus_out <= nxt_bus_out;
    end
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed self-checking bench for cpu_ctrl: a vector table of instructions
// plus hand-written reset, stall and halt sequences.
module tb_cpu_ctrl;

  typedef struct {
    logic [7:0] op;
    logic [7:0] imm;
    logic [7:0] rs_val;
    logic [7:0] rd_val;
    logic [2:0] sel;
    logic [7:0] res;
    int         lat;
    logic       z;
    logic       c;
    string      name;
  } vec_t;

`ifdef CPU_CTRL_FLAGS_EN
  localparam bit FlagsOn = 1'b1;
`else
  localparam bit FlagsOn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [2:0] reg_sel;
  logic       reg_rd;
  logic       reg_wr;
  logic       halted;
  logic       flag_z;
  logic       flag_c;

  logic [7:0] rf [8];
  int checkCount = 0;
  int passCount  = 0;
  vec_t vecs [8];

  always #5 clk = ~clk;

  // The register file answers reads combinationally, as the real one does.
  assign bus_in = reg_rd ? rf[reg_sel] : 8'h00;

  cpu_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .bus_in      (bus_in),
    .bus_out     (bus_out),
    .bus_oe      (bus_oe),
    .reg_sel     (reg_sel),
    .reg_rd      (reg_rd),
    .reg_wr      (reg_wr),
    .halted      (halted),
    .flag_z      (flag_z),
    .flag_c      (flag_c)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Offers one byte from the next falling edge and holds it until accepted.
  task automatic applyStimulus(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    instr       = b;
    instr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (instr_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  task automatic waitWrite(output int lat, output bit clash);
    lat   = 0;
    clash = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (reg_rd && bus_oe) clash = 1'b1;
      if (reg_wr) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic runVector(input vec_t v);
    bit ok;
    bit clash;
    int lat;
    rf[v.op[2:0]] = v.rs_val;
    rf[v.op[5:3]] = v.rd_val;
    applyStimulus(v.op, ok);
    checkOutput({v.name, " accept"}, ok, 1);
    if (v.op[7:6] == 2'b01) begin
      applyStimulus(v.imm, ok);
      checkOutput({v.name, " imm accept"}, ok, 1);
    end
    waitWrite(lat, clash);
    checkOutput({v.name, " latency"}, lat, v.lat);
    checkOutput({v.name, " reg_sel"}, reg_sel, v.sel);
    checkOutput({v.name, " bus_out"}, bus_out, v.res);
    checkOutput({v.name, " bus_oe"}, bus_oe, 1);
    checkOutput({v.name, " oe/rd clash"}, clash, 0);
    checkOutput({v.name, " flag_z"}, flag_z, FlagsOn & v.z);
    checkOutput({v.name, " flag_c"}, flag_c, FlagsOn & v.c);
    @(negedge clk);
    checkOutput({v.name, " single reg_wr"}, reg_wr, 0);
    checkOutput({v.name, " back to fetch"}, instr_ready, 1);
  endtask

  initial begin
    bit ok;
    bit clash;
    int lat;
    int bad;

    // Latency counts cycles from the last accepted byte to the reg_wr cycle.
    vecs[0] = '{8'h50, 8'h5A, 8'h00, 8'h00, 3'd2, 8'h5A, 1, 1'b0, 1'b0, "ldi r2,5a"};
    vecs[1] = '{8'h0A, 8'h00, 8'h5A, 8'h00, 3'd1, 8'h5A, 3, 1'b0, 1'b0, "mov r1,r2"};
    vecs[2] = '{8'h9C, 8'h00, 8'hF0, 8'h20, 3'd3, 8'h10, 4, 1'b0, 1'b1, "add r3,r4"};
    vecs[3] = '{8'h07, 8'h00, 8'h33, 8'h00, 3'd0, 8'h33, 3, 1'b0, 1'b1, "mov r0,r7"};
    vecs[4] = '{8'hAD, 8'h00, 8'h80, 8'h80, 3'd5, 8'h00, 4, 1'b1, 1'b1, "add r5,r5"};
    vecs[5] = '{8'h78, 8'hFF, 8'h00, 8'h00, 3'd7, 8'hFF, 1, 1'b1, 1'b1, "ldi r7,ff"};
    vecs[6] = '{8'hB1, 8'h00, 8'h01, 8'hFE, 3'd6, 8'hFF, 4, 1'b0, 1'b0, "add r6,r1"};
    vecs[7] = '{8'h82, 8'h00, 8'h0F, 8'hF1, 3'd0, 8'h00, 4, 1'b1, 1'b1, "add r0,r2"};

    for (int i = 0; i < 8; i++) rf[i] = 8'h00;
    rst         = 1'b0;
    instr       = 8'h00;
    instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset instr_ready", instr_ready, 0);
    checkOutput("reset reg_wr", reg_wr, 0);
    checkOutput("reset reg_rd", reg_rd, 0);
    checkOutput("reset bus_oe", bus_oe, 0);
    checkOutput("reset bus_out", bus_out, 0);
    checkOutput("reset halted", halted, 0);
    checkOutput("reset flag_z", flag_z, 0);
    checkOutput("reset flag_c", flag_c, 0);
    rst = 1'b1;
    #1 checkOutput("ready after reset", instr_ready, 1);

    for (int i = 0; i < 8; i++) runVector(vecs[i]);

    // FETCH with no valid byte: idle, ready, no strobes.
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (!instr_ready || reg_wr || reg_rd || bus_oe) bad++;
    end
    checkOutput("fetch stall", bad, 0);

    // LDI r3 with a gap in IMM before the immediate arrives.
    applyStimulus(8'h58, ok);
    checkOutput("ldi gap accept", ok, 1);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (reg_wr || reg_rd || bus_oe) bad++;
    end
    checkOutput("imm stall strobes", bad, 0);
    checkOutput("imm stall ready", instr_ready, 1);
    applyStimulus(8'h11, ok);
    waitWrite(lat, clash);
    checkOutput("ldi gap latency", lat, 1);
    checkOutput("ldi gap reg_sel", reg_sel, 3);
    checkOutput("ldi gap bus_out", bus_out, 8'h11);
    checkOutput("ldi gap flag_z held", flag_z, FlagsOn);
    checkOutput("ldi gap flag_c held", flag_c, FlagsOn);

    // NOP: one decode cycle, then back to fetch with no writes.
    applyStimulus(8'hC0, ok);
    @(negedge clk);
    checkOutput("nop decode ready", instr_ready, 0);
    @(negedge clk);
    checkOutput("nop back to fetch", instr_ready, 1);
    checkOutput("nop no write", reg_wr, 0);

    // Reset while the ADD is reading rd: the write must never happen.
    rf[4] = 8'hF0;
    rf[3] = 8'h20;
    applyStimulus(8'h9C, ok);
    repeat (3) @(negedge clk);
    checkOutput("add in rd_rd reg_rd", reg_rd, 1);
    checkOutput("add in rd_rd reg_sel", reg_sel, 3);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort ready", instr_ready, 1);
    checkOutput("abort reg_wr", reg_wr, 0);
    checkOutput("abort flag_z", flag_z, 0);
    checkOutput("abort flag_c", flag_c, 0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (reg_wr || reg_rd || bus_oe || !instr_ready) bad++;
    end
    checkOutput("abort no write", bad, 0);

    // HALT holds forever until a one-cycle reset.
    applyStimulus(8'hC7, ok);
    checkOutput("halt accept", ok, 1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("halted", halted, 1);
    checkOutput("halt ready", instr_ready, 0);
    instr       = 8'h50;
    instr_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!halted || instr_ready || reg_wr || reg_rd || bus_oe) bad++;
    end
    checkOutput("halt sticky", bad, 0);
    instr_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("unhalt halted", halted, 0);
    checkOutput("unhalt ready", instr_ready, 1);

    runVector(vecs[1]);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
